// File: rtl/sr_ff_driver_pkg.sv
// ============================================================================
// sr_ff_driver_pkg : shared encodings and counter sizing for the SR flop driver
// Rev 1.0
// ============================================================================
`default_nettype none

package sr_ff_driver_pkg;

   localparam logic [1:0] SR_IDLE  = 2'd0;
   localparam logic [1:0] SR_PULSE = 2'd1;
   localparam logic [1:0] SR_WAIT  = 2'd2;
   localparam logic [1:0] SR_FIN   = 2'd3;

   localparam logic [1:0] SR_ERR_NONE     = 2'b00;
   localparam logic [1:0] SR_ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] SR_ERR_FEEDBACK = 2'b10;

   // Width able to hold the larger terminal value without wrapping.
   function automatic int sr_cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sr_cycle_cnt.sv
// ============================================================================
// sr_cycle_cnt : loadable up-counter with clear, enable and terminal compare
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_cycle_cnt #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic [WIDTH-1:0] term_val,
   output logic             at_term
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign at_term = (r_count == term_val);

endmodule

`default_nettype wire

// File: rtl/sr_ff_driver.sv
// ============================================================================
// sr_ff_driver : drives an SR flop to a requested level, confirms via Q/QN
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_ff_driver
   import sr_ff_driver_pkg::*;
#(
   parameter int PULSE_LEN = 1,
   parameter int TIMEOUT   = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic       req_level,
   output logic       req_ready,
   output logic       set_out,
   output logic       reset_out,
   input  logic       q_fb,
   input  logic       qn_fb,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int CNT_W = sr_cnt_width(PULSE_LEN, TIMEOUT);
   localparam logic [CNT_W-1:0] c_pulse_term = CNT_W'(PULSE_LEN);
   localparam logic [CNT_W-1:0] c_wait_term  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

   logic [1:0] r_state, w_state_nxt;
   logic       r_level;
   logic       r_ready, r_set, r_reset, r_done, r_err;
   logic [1:0] r_err_code;

   logic       w_ready_nxt, w_set_nxt, w_reset_nxt, w_done_nxt, w_err_nxt;
   logic [1:0] w_err_code_nxt;
   logic       w_cnt_clr, w_cnt_load, w_cnt_en, w_cnt_at_term;
   logic [CNT_W-1:0] w_cnt_term;

   wire w_accept   = (r_state == SR_IDLE) && req_valid && r_ready;
   wire w_at_level = (q_fb == req_level) && (qn_fb == ~req_level);
   wire w_match    = (q_fb == r_level) && (qn_fb == ~r_level);

   assign w_cnt_term = (r_state == SR_PULSE) ? c_pulse_term : c_wait_term;

   sr_cycle_cnt #(.WIDTH(CNT_W)) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (w_cnt_clr),
      .load     (w_cnt_load),
      .load_val (c_one),
      .en       (w_cnt_en),
      .term_val (w_cnt_term),
      .at_term  (w_cnt_at_term)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= SR_IDLE;
         r_level    <= 1'b0;
         r_ready    <= 1'b0;
         r_set      <= 1'b0;
         r_reset    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= SR_ERR_NONE;
      end else begin
         r_state    <= w_state_nxt;
         r_ready    <= w_ready_nxt;
         r_set      <= w_set_nxt;
         r_reset    <= w_reset_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_err_code <= w_err_code_nxt;
         if (w_accept) begin
            r_level <= req_level;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SR_IDLE:  if (w_accept) w_state_nxt = w_at_level ? SR_FIN : SR_PULSE;
         SR_PULSE: if (w_cnt_at_term) w_state_nxt = SR_WAIT;
         SR_WAIT: begin
            if (w_match)            w_state_nxt = SR_FIN;
            else if (w_cnt_at_term) w_state_nxt = SR_IDLE;
         end
         default:  w_state_nxt = SR_IDLE;
      endcase
   end

   // Pulse counter is preloaded with 1 at acceptance so the pulse spans exactly PULSE_LEN cycles.
   always_comb begin
      w_ready_nxt    = 1'b0;
      w_set_nxt      = 1'b0;
      w_reset_nxt    = 1'b0;
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      w_err_code_nxt = r_err_code;
      w_cnt_clr      = 1'b0;
      w_cnt_load     = 1'b0;
      w_cnt_en       = 1'b0;
      case (r_state)
         SR_IDLE: begin
            if (w_accept) begin
               w_err_code_nxt = SR_ERR_NONE;
               if (!w_at_level) begin
                  w_set_nxt   = req_level;
                  w_reset_nxt = ~req_level;
                  w_cnt_load  = 1'b1;
               end
            end else begin
               w_ready_nxt = 1'b1;
            end
         end
         SR_PULSE: begin
            if (w_cnt_at_term) begin
               w_cnt_clr = 1'b1;
            end else begin
               w_set_nxt   = r_level;
               w_reset_nxt = ~r_level;
               w_cnt_en    = 1'b1;
            end
         end
         SR_WAIT: begin
            if (!w_match) begin
               if (w_cnt_at_term) begin
                  w_err_nxt      = 1'b1;
                  w_ready_nxt    = 1'b1;
                  w_err_code_nxt = (q_fb == qn_fb) ? SR_ERR_FEEDBACK : SR_ERR_TIMEOUT;
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
         end
         default: begin
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   assign req_ready = r_ready;
   assign set_out   = r_set;
   assign reset_out = r_reset;
   assign done      = r_done;
   assign err       = r_err;
   assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_sr_ff_driver.sv
// ============================================================================
// tb_sr_ff_driver : directed checks of sr_ff_driver against a behavioural SR flop
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_sr_ff_driver;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_level = 1'b0;
   logic       req_ready, set_out, reset_out, done, err;
   logic [1:0] err_code;
   logic       q_fb, qn_fb;

   logic       ff_q;
   logic       force_en = 1'b0;
   logic       force_q  = 1'b0;
   logic       force_qn = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #1 clk = ~clk;

   // Behavioural SR flop, SET dominant; optionally overridden to inject bad feedback.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)       ff_q <= 1'b0;
      else if (set_out)   ff_q <= 1'b1;
      else if (reset_out) ff_q <= 1'b0;
   end

   assign q_fb  = force_en ? force_q  : ff_q;
   assign qn_fb = force_en ? force_qn : ~ff_q;

   sr_ff_driver #(.PULSE_LEN(2), .TIMEOUT(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_level (req_level),
      .req_ready (req_ready),
      .set_out   (set_out),
      .reset_out (reset_out),
      .q_fb      (q_fb),
      .qn_fb     (qn_fb),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Issue one request; lat counts rising edges from acceptance to DONE/ERR.
   task automatic run_req(input logic lvl, input bit hold, output int lat,
                          output int n_set, output int n_rst, output bit got_done,
                          output bit got_err, output int code);
      int guard;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("ready_before_req", int'(req_ready), 1);
      req_valid = 1'b1;
      req_level = lvl;
      lat = -1; n_set = 0; n_rst = 0; got_done = 0; got_err = 0; code = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check_eq("accepted", int'(req_ready), 0);
            check_eq("code_cleared", int'(err_code), 0);
            if (!hold) req_valid = 1'b0;
         end
         if (set_out)   n_set++;
         if (reset_out) n_rst++;
         if (set_out && reset_out) check_eq("set_reset_excl", 1, 0);
         if (done || err) begin
            lat      = k - 1;
            got_done = done;
            got_err  = err;
            code     = int'(err_code);
            check_eq("ready_at_end", int'(req_ready), 1);
            check_eq("done_err_excl", int'(done & err), 0);
            break;
         end
      end
      if (lat < 0) check_eq("completion_timeout", 0, 1);
   endtask

   initial begin
      int lat, ns, nr, code;
      bit gd, ge;

      // Reset state
      @(negedge clk);
      check_eq("rst_ready", int'(req_ready), 0);
      check_eq("rst_set", int'(set_out), 0);
      check_eq("rst_reset", int'(reset_out), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_err", int'(err), 0);
      check_eq("rst_code", int'(err_code), 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", int'(req_ready), 1);

      // Set from 0
      run_req(1'b1, 0, lat, ns, nr, gd, ge, code);
      check_eq("t1_lat", lat, 4);
      check_eq("t1_set_cycles", ns, 2);
      check_eq("t1_reset_cycles", nr, 0);
      check_eq("t1_done", int'(gd), 1);
      check_eq("t1_err", int'(ge), 0);
      check_eq("t1_code", code, 0);
      check_eq("t1_q", int'(q_fb), 1);
      check_eq("t1_qn", int'(qn_fb), 0);

      // Back-to-back: 0 then 1 with valid held through the first DONE
      run_req(1'b0, 1, lat, ns, nr, gd, ge, code);
      check_eq("t2a_lat", lat, 4);
      check_eq("t2a_reset_cycles", nr, 2);
      check_eq("t2a_set_cycles", ns, 0);
      check_eq("t2a_done", int'(gd), 1);
      check_eq("t2a_valid_held", int'(req_valid), 1);
      run_req(1'b1, 0, lat, ns, nr, gd, ge, code);
      check_eq("t2b_lat", lat, 4);
      check_eq("t2b_set_cycles", ns, 2);
      check_eq("t2b_reset_cycles", nr, 0);
      check_eq("t2b_done", int'(gd), 1);
      check_eq("t2b_q", int'(q_fb), 1);

      // Already at level
      run_req(1'b1, 0, lat, ns, nr, gd, ge, code);
      check_eq("t3_lat", lat, 1);
      check_eq("t3_set_cycles", ns, 0);
      check_eq("t3_reset_cycles", nr, 0);
      check_eq("t3_done", int'(gd), 1);

      // Stuck feedback -> timeout
      force_en = 1'b1; force_q = 1'b0; force_qn = 1'b1;
      run_req(1'b1, 0, lat, ns, nr, gd, ge, code);
      check_eq("t4_lat", lat, 11);
      check_eq("t4_set_cycles", ns, 2);
      check_eq("t4_err", int'(ge), 1);
      check_eq("t4_done", int'(gd), 0);
      check_eq("t4_code", code, 1);

      // Illegal feedback Q == QN
      force_q = 1'b1; force_qn = 1'b1;
      run_req(1'b0, 0, lat, ns, nr, gd, ge, code);
      check_eq("t5_lat", lat, 11);
      check_eq("t5_reset_cycles", nr, 2);
      check_eq("t5_err", int'(ge), 1);
      check_eq("t5_code", code, 2);
      force_en = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t5_code_holds", int'(err_code), 2);
      check_eq("t5_err_one_cycle", int'(err), 0);
      run_req(1'b0, 0, lat, ns, nr, gd, ge, code);
      check_eq("t5b_lat", lat, 1);
      check_eq("t5b_done", int'(gd), 1);
      check_eq("t5b_code", code, 0);

      // Reset asserted mid-pulse
      req_valid = 1'b1; req_level = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("t6_set_in_pulse", int'(set_out), 1);
      reset_n = 1'b0;
      #0.2;
      check_eq("t6_set_cleared", int'(set_out), 0);
      check_eq("t6_ready_cleared", int'(req_ready), 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("t6_no_done_err", int'(done | err), 0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("t6_ready_after_rel", int'(req_ready), 1);
      check_eq("t6_no_done_err_rel", int'(done | err), 0);
      run_req(1'b1, 0, lat, ns, nr, gd, ge, code);
      check_eq("t6_lat", lat, 4);
      check_eq("t6_set_cycles", ns, 2);
      check_eq("t6_done", int'(gd), 1);
      check_eq("t6_q", int'(q_fb), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
